// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline-stage register.
// Stage states and occupancy width.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int OCC_W = 2;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a pipeline stage register and its neighbours.
// slave is the stage's view, master is the driving/observing side.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 20,
    parameter int DATA_W = 128
) ();

    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occupancy;

    modport slave (
        input  flush, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    modport master (
        output flush, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );

endinterface

// File: rtl/pipe_slot.sv
// One pipeline entry: valid + control + data with load and clear.
// Clear beats load and wipes control only; data is kept for bubbles.
module pipe_slot #(
    parameter int CTRL_W = 20,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register with optional skid entry and flush.
// Control reads as zero whenever no valid entry is presented.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 20,
    parameter int DATA_W = 128,
    parameter bit SKID   = 1'b1
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_reg_if.slave bus
);

    logic              accept;
    logic              rel;
    logic              main_load;
    logic              main_clear;
    logic              main_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;

    assign accept = bus.in_valid & bus.in_ready;
    assign rel    = main_v & bus.out_ready;

    assign bus.out_valid = main_v;
    assign bus.out_ctrl  = main_v ? main_ctrl : '0;
    assign bus.out_data  = main_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clear),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .valid  (main_v),
        .ctrl   (main_ctrl),
        .data   (main_data)
    );

    if (SKID) begin : g_skid
        state_t            state_q;
        state_t            state_d;
        logic              rdy_q;
        logic              skid_load;
        logic              skid_clear;
        logic              skid_v;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] skid_data;

        pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk    (clk),
            .rst    (rst),
            .load   (skid_load),
            .clear  (skid_clear),
            .d_ctrl (bus.in_ctrl),
            .d_data (bus.in_data),
            .valid  (skid_v),
            .ctrl   (skid_ctrl),
            .data   (skid_data)
        );

        // in_ready is registered from the next state to cut the comb path
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= EMPTY;
                rdy_q   <= 1'b1;
            end else begin
                state_q <= state_d;
                rdy_q   <= (state_d != TWO);
            end
        end

        always_comb begin
            state_d = state_q;
            if (bus.flush) begin
                state_d = EMPTY;
            end else begin
                case (state_q)
                    EMPTY: if (accept) state_d = ONE;
                    ONE: begin
                        if (accept && !rel)
                            state_d = TWO;
                        else if (!accept && rel)
                            state_d = EMPTY;
                    end
                    TWO: if (rel) state_d = ONE;
                    default: state_d = EMPTY;
                endcase
            end
        end

        always_comb begin
            main_load   = 1'b0;
            main_clear  = bus.flush;
            skid_load   = 1'b0;
            skid_clear  = bus.flush;
            main_d_ctrl = bus.in_ctrl;
            main_d_data = bus.in_data;
            case (state_q)
                EMPTY: main_load = accept;
                ONE: begin
                    main_load  = accept & rel;
                    skid_load  = accept & ~rel;
                    main_clear = bus.flush | (rel & ~accept);
                end
                TWO: begin
                    main_load   = rel;
                    skid_clear  = bus.flush | rel;
                    main_d_ctrl = skid_ctrl;
                    main_d_data = skid_data;
                end
                default: main_clear = 1'b1;
            endcase
        end

        assign bus.in_ready  = rdy_q;
        assign bus.occupancy = OCC_W'(main_v) + OCC_W'(skid_v);
    end else begin : g_single
        assign bus.in_ready  = ~main_v | bus.out_ready;
        assign main_load     = accept;
        assign main_clear    = bus.flush | (rel & ~accept);
        assign main_d_ctrl   = bus.in_ctrl;
        assign main_d_data   = bus.in_data;
        assign bus.occupancy = OCC_W'(main_v);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg, both skid and single-entry builds.
// Accepted entries are queued and matched in order on release.
module tb_pipe_stage_reg;

    localparam int CW = 20;
    localparam int DW = 128;

    typedef logic [CW+DW-1:0] ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    ent_t sb1[$];
    ent_t sb0[$];

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) b1 ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) b0 ();

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    task automatic chk(input string tag, input ent_t obs, input ent_t want);
        n_assert++;
        assert (obs === want)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic drv1(input logic v, input int c, input logic [DW-1:0] d);
        b1.in_valid = v;
        b1.in_ctrl  = CW'(c);
        b1.in_data  = d;
    endtask

    task automatic drv0(input logic v, input int c, input logic [DW-1:0] d);
        b0.in_valid = v;
        b0.in_ctrl  = CW'(c);
        b0.in_data  = d;
    endtask

    // sample handshakes mid-cycle, then advance to just past the edge
    task automatic step();
        ent_t e;
        @(negedge clk);
        if (b1.out_valid && b1.out_ready) begin
            chk("sb1_pending", ent_t'(sb1.size() != 0), 1);
            if (sb1.size() != 0) begin
                e = sb1.pop_front();
                chk("sb1_entry", {b1.out_ctrl, b1.out_data}, e);
            end
        end
        if (b1.flush)
            sb1.delete();
        else if (b1.in_valid && b1.in_ready)
            sb1.push_back({b1.in_ctrl, b1.in_data});
        if (b0.out_valid && b0.out_ready) begin
            chk("sb0_pending", ent_t'(sb0.size() != 0), 1);
            if (sb0.size() != 0) begin
                e = sb0.pop_front();
                chk("sb0_entry", {b0.out_ctrl, b0.out_data}, e);
            end
        end
        if (b0.flush)
            sb0.delete();
        else if (b0.in_valid && b0.in_ready)
            sb0.push_back({b0.in_ctrl, b0.in_data});
        @(posedge clk);
        #1;
    endtask

    initial begin
        b1.flush = 1'b0;
        b1.out_ready = 1'b1;
        drv1(1'b0, 0, '0);
        b0.flush = 1'b0;
        b0.out_ready = 1'b1;
        drv0(1'b0, 0, '0);

        #1 rst = 1'b1;
        #1;
        chk("rst1_valid", b1.out_valid, 0);
        chk("rst1_ctrl", b1.out_ctrl, 0);
        chk("rst1_data", b1.out_data, 0);
        chk("rst1_occ", b1.occupancy, 0);
        chk("rst1_ready", b1.in_ready, 1);
        chk("rst0_valid", b0.out_valid, 0);
        chk("rst0_occ", b0.occupancy, 0);
        chk("rst0_ready", b0.in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // streaming 1..8, one cycle latency, no gaps
        for (int i = 1; i <= 8; i++) begin
            drv1(1'b1, i, DW'(i * 32'h1111));
            step();
            chk("stream_valid", b1.out_valid, 1);
            chk("stream_ctrl", b1.out_ctrl, ent_t'(i));
            chk("stream_occ", b1.occupancy, 1);
        end
        drv1(1'b0, 0, '0);
        step();
        chk("stream_drain", b1.out_valid, 0);

        // backpressure: stall one cycle while 6 arrives
        drv1(1'b1, 5, DW'(5));
        step();
        chk("bp_head", b1.out_ctrl, 5);
        drv1(1'b1, 6, DW'(6));
        b1.out_ready = 1'b0;
        step();
        chk("bp_occ2", b1.occupancy, 2);
        chk("bp_notready", b1.in_ready, 0);
        chk("bp_stall", b1.out_ctrl, 5);
        drv1(1'b1, 7, DW'(7));
        b1.out_ready = 1'b1;
        step();
        chk("bp_occ1", b1.occupancy, 1);
        chk("bp_ready", b1.in_ready, 1);
        chk("bp_second", b1.out_ctrl, 6);
        step();
        chk("bp_third", b1.out_ctrl, 7);
        drv1(1'b0, 0, '0);
        step();
        chk("bp_empty", b1.occupancy, 0);

        // flush with simultaneous accept
        drv1(1'b1, 3, DW'(3));
        step();
        chk("fl_occ1", b1.occupancy, 1);
        drv1(1'b1, 4, DW'(4));
        b1.flush = 1'b1;
        b1.out_ready = 1'b0;
        step();
        chk("fl_valid", b1.out_valid, 0);
        chk("fl_ctrl", b1.out_ctrl, 0);
        chk("fl_occ", b1.occupancy, 0);
        chk("fl_ready", b1.in_ready, 1);
        b1.flush = 1'b0;
        b1.out_ready = 1'b1;
        drv1(1'b0, 0, '0);
        repeat (2) begin
            step();
            chk("fl_no4", b1.out_valid, 0);
        end

        // bubble keeps data, zeroes control
        drv1(1'b1, 9, DW'(16'hDEAD));
        step();
        drv1(1'b0, 0, '0);
        step();
        chk("bub_valid", b1.out_valid, 0);
        chk("bub_ctrl", b1.out_ctrl, 0);
        chk("bub_data", b1.out_data, 16'hDEAD);
        step();
        chk("bub_hold", b1.out_data, 16'hDEAD);

        // async reset while full
        b1.out_ready = 1'b0;
        drv1(1'b1, 10, DW'(10));
        step();
        drv1(1'b1, 11, DW'(11));
        step();
        chk("mr_occ2", b1.occupancy, 2);
        drv1(1'b0, 0, '0);
        rst = 1'b1;
        sb1.delete();
        sb0.delete();
        #1;
        chk("mr_valid", b1.out_valid, 0);
        chk("mr_ctrl", b1.out_ctrl, 0);
        chk("mr_occ", b1.occupancy, 0);
        chk("mr_ready", b1.in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        b1.out_ready = 1'b1;
        drv1(1'b1, 12, DW'(12));
        step();
        chk("mr_first", b1.out_ctrl, 12);
        chk("mr_first_occ", b1.occupancy, 1);
        drv1(1'b0, 0, '0);
        step();

        // single-entry build
        b0.out_ready = 1'b0;
        drv0(1'b1, 'h11, DW'(1));
        step();
        chk("s0_valid", b0.out_valid, 1);
        chk("s0_ctrl", b0.out_ctrl, 'h11);
        chk("s0_occ", b0.occupancy, 1);
        chk("s0_notready", b0.in_ready, 0);
        drv0(1'b1, 'h99, DW'(9));
        step();
        chk("s0_stall", b0.out_ctrl, 'h11);
        b0.out_ready = 1'b1;
        drv0(1'b1, 'h12, DW'(2));
        #1;
        chk("s0_comb_ready", b0.in_ready, 1);
        step();
        chk("s0_swap", b0.out_ctrl, 'h12);
        chk("s0_swap_occ", b0.occupancy, 1);
        for (int i = 'h13; i <= 'h15; i++) begin
            drv0(1'b1, i, DW'(i));
            step();
            chk("s0_stream", b0.out_ctrl, ent_t'(i));
        end
        drv0(1'b0, 0, '0);
        step();
        chk("s0_empty", b0.out_valid, 0);
        chk("s0_empty_occ", b0.occupancy, 0);

        chk("sb1_drained", ent_t'(sb1.size()), 0);
        chk("sb0_drained", ent_t'(sb0.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data field behind a valid/ready handshake, with an optional skid entry, synchronous flush and bubble semantics. Downstream always sees all-zero control when the stage holds no valid instruction. It replaces the per-boundary fixed-width register files in the core.

## Interface
- CTRL_W, 20: width of control field (write enables, op selects); zeroed on bubble.
- DATA_W, 128: width of data field (operands, immediate, pc4, wR); not zeroed on bubble.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry, combinational in_ready.

- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream holds an instruction.
- in_ready  output  1  stage accepts this cycle.
- in_ctrl  input  CTRL_W  upstream control.
- in_data  input  DATA_W  upstream data.
- out_valid  output  1  stage presents an instruction.
- out_ready  input  1  downstream accepts this cycle.
- out_ctrl  output  CTRL_W  control; forced 0 when out_valid=0.
- out_data  output  DATA_W  data; holds last value when out_valid=0.
- occupancy  output  2  entries held (0..2; max 1 when SKID=0).

## Operation
- Accept = in_valid & in_ready; release = out_valid & out_ready.
- SKID=1 states: EMPTY, ONE (main slot), TWO (main + skid slot).
  - EMPTY: accept -> ONE, load main.
  - ONE: accept & !release -> TWO, load skid; accept & release -> ONE, load main; !accept & release -> EMPTY.
  - TWO: release -> ONE, skid moves to main; no accept possible (in_ready=0).
  - in_ready = (state != TWO), driven from a register.
- SKID=0: single slot; in_ready = !out_valid | out_ready; accept loads slot, release without accept empties it.
- out_valid = main slot valid; out_ctrl = out_valid ? main_ctrl : 0; out_data = main_data.
- Flush: next edge -> EMPTY, all valid bits 0, occupancy 0. Flush beats simultaneous accept (input dropped, not loaded) and release (release still counts downstream that cycle).
- Data field never cleared except by reset; control field cleared on flush and reset.
- Order preserved; no entry duplicated or dropped except by flush.

## Timing
- Reset (async assert): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 (SKID=1 reg reset to 1; SKID=0 follows from out_valid=0).
- Latency: accept at edge N -> out_valid=1 with that entry after edge N (visible cycle N+1).
- Throughput: 1 per cycle sustained when out_ready=1 continuously, both modes.
- SKID=1: out_ready deasserted for one cycle while full stream -> one entry captured in skid, in_ready low next cycle, no loss.
- Stall (out_ready=0, out_valid=1): out_ctrl/out_data stable until release.
- Reset release mid-stream: first edge after rst deassert behaves as EMPTY.
- in_valid/in_ctrl/in_data need not be stable while in_ready=0.

## Structure
- Package pipe_pkg: state enum {EMPTY, ONE, TWO} and OCC_W=2 constant.
- Sub-module pipe_slot: valid + ctrl + data register with load/clear, async reset; instantiated twice (SKID=1) or once (SKID=0) via generate.

## Test plan
- Reset: assert rst mid-stream with occupancy 2 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1 immediately.
- Streaming, SKID=1, out_ready=1: push ctrl 1..8 on consecutive cycles -> out_ctrl 1..8 one cycle later each, no gaps.
- Backpressure: stream ctrl 5,6,7, drop out_ready at cycle of 6 for 1 cycle -> occupancy 2, in_ready=0 for one cycle, output order 5,6,7 intact.
- Flush with accept: occupancy 1 (ctrl 0x3), flush=1 and in_valid=1 (ctrl 0x4) same cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0; 0x4 never appears.
- Bubble: after release of data 0xDEAD with no new input -> out_valid=0, out_ctrl=0, out_data stays 0xDEAD.
- SKID=0: out_ready=0 with valid entry -> in_ready=0 combinationally; raise out_ready with in_valid=1 -> release and accept same edge, in_ready=1 that cycle.
